sm83_oam_dma_ctrl: RTL
======================

// Module: sm83_oam_dma_ctrl
// PURPOSE
// - OAM DMA sequencer and bus arbiter.
// - A write to the DMA register (FF46) starts a copy of N_BYTES bytes from src_hi:00 to FE00.
// - Copies one byte per M-cycle.
// - While the copy is active, CPU access is restricted to HRAM.
// - Sits between the sm83 core bus, the external/WRAM bus and the OAM write port.
// PARAMETERS
// - N_BYTES  160       bytes per transfer (index width 8 bits; N_BYTES<=256)
// - HRAM_LO  16'hFF80  lowest CPU address still granted while busy
// - HRAM_HI  16'hFFFE  highest CPU address still granted while busy
// PORTS
// - clk        in   1   single system clock
// - reset      in   1   synchronous, active-high reset
// - mcyc_en    in   1   one-clk pulse per M-cycle; all state advances only on clk with mcyc_en=1
// - reg_wr     in   1   CPU write strobe to FF46 (sampled with mcyc_en)
// - reg_wdata  in   8   source page written to FF46
// - reg_rdata  out  8   FF46 readback = last written value
// - cpu_addr   in   16  CPU bus address
// - cpu_req    in   1   CPU bus access request
// - cpu_gnt    out  1   CPU access forwarded to memory (combinational)
// - cpu_rdata  out  8   mem_rdata when granted, else 8'hFF
// - dma_rd     out  1   DMA drives source bus this M-cycle
// - dma_addr   out  16  DMA source address
// - mem_rdata  in   8   source bus read data, valid at end of M-cycle
// - oam_we     out  1   OAM write this M-cycle
// - oam_addr   out  8   OAM byte index
// - oam_wdata  out  8   byte written to OAM
// - busy       out  1   CPU bus blocked (non-HRAM)
// BEHAVIOUR
// - Reset: state=IDLE, idx=0, src_hi=8'h00; reg_rdata=0, busy=0, dma_rd=0, oam_we=0, dma_addr=0, oam_addr=0, oam_wdata=0.
// - Reset dominates mcyc_en and reg_wr. Reset mid-transfer aborts at once: no further OAM writes.
// - Source mapping: src_hi = reg_wdata; if reg_wdata>=8'hE0, bit5 is cleared (echo-RAM alias, e.g. E1->C1). reg_rdata keeps the unmapped value.
// - FSM (transitions on clk & mcyc_en):
//   - IDLE: reg_wr -> START.
//   - START: one M-cycle, no bus activity -> XFER with idx=0.
//   - XFER: dma_rd=1, dma_addr={src_hi,idx}. At the end of the cycle, mem_rdata is latched to oam_wdata and oam_addr=idx; the next cycle has oam_we=1. idx increments; idx==N_BYTES-1 -> DRAIN.
//   - DRAIN: dma_rd=0; oam_we=1 for the last byte -> IDLE.
// - Pipelining: the OAM write of byte i overlaps the read of byte i+1. oam_we is high in M-cycles 1..N_BYTES after the first read.
// - Latency: reg_wr at M-cycle k -> START at k+1 -> first read at k+2 -> last OAM write at k+N_BYTES+2 -> IDLE at k+N_BYTES+3.
// - busy timing:
//   - busy=1 in XFER and DRAIN.
//   - In START, busy=1 only when START was entered from XFER/DRAIN (restart); it is 0 for a fresh start.
//   - busy is registered and changes on mcyc_en edges.
// - Restart: reg_wr in XFER/DRAIN -> START with the new src_hi and idx reset to 0.
//   - A pending OAM write of the previous byte still completes in the START cycle.
//   - No further bytes of the old transfer.
//   - reg_wr in START reloads src_hi and stays in START for one more M-cycle.
// - Arbitration (combinational):
//   - cpu_gnt = cpu_req & (!busy | (cpu_addr>=HRAM_LO & cpu_addr<=HRAM_HI)).
//   - Ungranted CPU reads see 8'hFF. Ungranted writes are dropped.
//   - DMA never yields to the CPU.
// - A reg_wr without mcyc_en is ignored.
// - oam_we/dma_rd are 0 in IDLE/START unless stated above.
// TESTING
// - Reset then idle 10 M-cycles -> all outputs 0, cpu_gnt follows cpu_req for any address.
// - reg_wr=8'hC1 at M-cycle 0:
//   - dma_addr=C100 at M2, C19F at M161.
//   - oam_we M3..M162 with oam_addr 00..9F and oam_wdata equal to the source bytes.
//   - busy 1 in M2..M162, 0 at M163.
// - During a transfer: cpu_req at 8000 -> cpu_gnt=0, cpu_rdata=FF. At FF80 and FFFE -> gnt=1. At FFFF -> gnt=0.
// - reg_wr=8'hE5 -> reads from C500..C59F; reg_rdata=E5.
// - Restart with 8'h80 at idx=50:
//   - byte 49 is still written in START.
//   - reads restart at 8000.
//   - busy never drops.
//   - 160 new OAM writes.
// - reset asserted at idx=20 -> next clk: busy=0, oam_we=0, state IDLE. A subsequent reg_wr starts cleanly at idx 0.

Source files
------------

// File: rtl/sm83_oam_dma_ctrl.sv
// OAM DMA sequencer: copies N_BYTES from src_hi:00 to OAM, one byte per M-cycle,
// and fences the CPU off everything but HRAM while the copy is running.
module sm83_oam_dma_ctrl #(
    parameter int          N_BYTES = 160,
    parameter logic [15:0] HRAM_LO = 16'hFF80,
    parameter logic [15:0] HRAM_HI = 16'hFFFE
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_mcyc_en,
    input  logic        i_reg_wr,
    input  logic [7:0]  i_reg_wdata,
    output logic [7:0]  o_reg_rdata,
    input  logic [15:0] i_cpu_addr,
    input  logic        i_cpu_req,
    output logic        o_cpu_gnt,
    output logic [7:0]  o_cpu_rdata,
    output logic        o_dma_rd,
    output logic [15:0] o_dma_addr,
    input  logic [7:0]  i_mem_rdata,
    output logic        o_oam_we,
    output logic [7:0]  o_oam_addr,
    output logic [7:0]  o_oam_wdata,
    output logic        o_busy
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_XFER, S_DRAIN} state_t;

    localparam logic [7:0] LAST_IDX = 8'(N_BYTES - 1);

    state_t      r_state;
    logic [7:0]  r_idx;      // index of the next byte to read
    logic [7:0]  r_src_hi;
    logic [7:0]  r_reg;
    logic        r_dma_rd;
    logic [15:0] r_dma_addr;
    logic        r_oam_we;
    logic [7:0]  r_oam_addr;
    logic [7:0]  r_oam_wdata;
    logic        r_busy;

    logic [7:0]  w_src_map;
    logic        w_hram;

    // Pages E0..FF alias onto C0..DF (echo RAM)
    assign w_src_map = (i_reg_wdata >= 8'hE0) ? (i_reg_wdata & 8'hDF) : i_reg_wdata;
    assign w_hram    = (i_cpu_addr >= HRAM_LO) && (i_cpu_addr <= HRAM_HI);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_idx       <= 8'h00;
            r_src_hi    <= 8'h00;
            r_reg       <= 8'h00;
            r_dma_rd    <= 1'b0;
            r_dma_addr  <= 16'h0000;
            r_oam_we    <= 1'b0;
            r_oam_addr  <= 8'h00;
            r_oam_wdata <= 8'h00;
            r_busy      <= 1'b0;
        end else if (i_mcyc_en) begin
            r_oam_we <= 1'b0;
            if (i_reg_wr) begin
                r_reg    <= i_reg_wdata;
                r_src_hi <= w_src_map;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_reg_wr) r_state <= S_START;
                end
                S_START: begin
                    // A reload here keeps START (and busy) for another M-cycle
                    if (!i_reg_wr) begin
                        r_state    <= S_XFER;
                        r_dma_rd   <= 1'b1;
                        r_dma_addr <= {r_src_hi, 8'h00};
                        r_idx      <= 8'h01;
                        r_busy     <= 1'b1;
                    end
                end
                S_XFER: begin
                    // The byte read this cycle is always written next cycle, even on restart
                    r_oam_we    <= 1'b1;
                    r_oam_addr  <= r_dma_addr[7:0];
                    r_oam_wdata <= i_mem_rdata;
                    if (i_reg_wr) begin
                        r_state  <= S_START;
                        r_dma_rd <= 1'b0;
                        r_idx    <= 8'h00;
                    end else if (r_dma_addr[7:0] == LAST_IDX) begin
                        r_state  <= S_DRAIN;
                        r_dma_rd <= 1'b0;
                    end else begin
                        r_dma_addr[7:0] <= r_idx;
                        r_idx           <= r_idx + 8'h01;
                    end
                end
                S_DRAIN: begin
                    if (i_reg_wr) begin
                        r_state <= S_START;
                        r_idx   <= 8'h00;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_cpu_gnt   = i_cpu_req && (!r_busy || w_hram);
    assign o_cpu_rdata = o_cpu_gnt ? i_mem_rdata : 8'hFF;
    assign o_reg_rdata = r_reg;
    assign o_dma_rd    = r_dma_rd;
    assign o_dma_addr  = r_dma_addr;
    assign o_oam_we    = r_oam_we;
    assign o_oam_addr  = r_oam_addr;
    assign o_oam_wdata = r_oam_wdata;
    assign o_busy      = r_busy;
endmodule
